// File: rtl/alu_seq_if.sv
// Operand/result bundle between the SLURM execute stage (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int BITS = 16
);
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [4:0]      aluOp;
  logic            start;
  logic            busy;
  logic            done;
  logic [BITS-1:0] aluOut;
  logic            C;
  logic            Z;
  logic            S;
  logic            V;

  modport master (
    output A, B, aluOp, start,
    input  busy, done, aluOut, C, Z, S, V
  );

  modport slave (
    input  A, B, aluOp, start,
    output busy, done, aluOut, C, Z, S, V
  );
endinterface

// File: rtl/alu_seq.sv
// SLURM multi-cycle ALU: single-cycle ops give done one clock after start; mul/muls iterate BITS cycles
// under busy when SLURM_ALU_MUL_EN is defined (otherwise ops 8/9 are NOPs). Starts seen while busy are dropped.
module alu_seq #(
  parameter int BITS = 16
) (
  input logic      CLK,
  input logic      RSTb,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(BITS);
  localparam int M   = BITS - 1;

  typedef enum logic [4:0] {
    OP_MOV,  OP_ADD,  OP_ADC,  OP_SUB,   OP_SBB,   OP_AND,  OP_OR,   OP_XOR,
    OP_MUL,  OP_MULS, OP_BSR,  OP_BSL,   OP_CMP,   OP_TEST, OP_MFHI, OP_NOP15,
    OP_ASR,  OP_LSR,  OP_LSL,  OP_ROLC,  OP_RORC,  OP_ROL,  OP_ROR,  OP_CLC,
    OP_SEC,  OP_CLZ,  OP_SEZ,  OP_CLS,   OP_SES,   OP_PUSHF, OP_POPF, OP_NOP31
  } aluOp_t;

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state, stateNext;
  aluOp_t          op;
  logic [BITS-1:0] a, b;
  logic [BITS-1:0] hiVal, resN, outR, mulLo;
  logic [SHW-1:0]  shAmt;
  logic [BITS:0]   sumW, shlW, shrW;
  logic            cR, zR, sR, vR;
  logic            cN, zN, sN, vN;
  logic            updZS, doneR, busyC;
  logic            accept, goMul, mulDone, mulOvf, mulZero, mulSign;

  assign a      = bus.A;
  assign b      = bus.B;
  assign op     = aluOp_t'(bus.aluOp);
  assign shAmt  = b[SHW-1:0];
  assign accept = bus.start && (state == IDLE);

  // ---------------- control FSM ----------------
  always_ff @(posedge CLK) begin
    if (!RSTb) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busyC     = 1'b0;
    unique case (state)
      IDLE: if (goMul) stateNext = MUL;
      MUL: begin
        busyC = 1'b1;
        if (mulDone) stateNext = IDLE;
      end
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  always_comb begin
    resN  = '0;
    cN    = cR;
    zN    = zR;
    sN    = sR;
    vN    = vR;
    updZS = 1'b0;
    sumW  = '0;
    shlW  = '0;
    shrW  = '0;
    unique case (op)
      OP_MOV: resN = b;
      OP_ADD, OP_ADC: begin
        sumW  = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, (op == OP_ADC) & cR};
        resN  = sumW[M:0];
        cN    = sumW[BITS];
        vN    = (a[M] == b[M]) && (sumW[M] != a[M]);
        updZS = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // bit BITS of the widened difference is the borrow
        sumW = {1'b0, a} - {1'b0, b} - {{BITS{1'b0}}, (op == OP_SBB) & cR};
        resN = (op == OP_CMP) ? a : sumW[M:0];
        cN   = sumW[BITS];
        vN   = (a[M] != b[M]) && (sumW[M] != a[M]);
        zN   = (sumW[M:0] == '0);
        sN   = sumW[M];
      end
      OP_AND, OP_OR, OP_XOR: begin
        resN  = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
        cN    = 1'b0;
        vN    = 1'b0;
        updZS = 1'b1;
      end
      OP_BSR: begin
        shrW  = {a, 1'b0} >> shAmt;
        resN  = shrW[BITS:1];
        if (shAmt != '0) cN = shrW[0];
        updZS = 1'b1;
      end
      OP_BSL: begin
        shlW  = {1'b0, a} << shAmt;
        resN  = shlW[M:0];
        if (shAmt != '0) cN = shlW[BITS];
        updZS = 1'b1;
      end
      OP_TEST: begin
        resN = a;
        zN   = ((a & b) == '0);
        sN   = a[M] & b[M];
      end
      OP_MFHI: resN = hiVal;
      OP_ASR: begin
        resN  = {b[M], b[M:1]};
        cN    = b[0];
        updZS = 1'b1;
      end
      OP_LSR: begin
        resN  = {1'b0, b[M:1]};
        cN    = b[0];
        updZS = 1'b1;
      end
      OP_LSL: begin
        resN  = {b[M-1:0], 1'b0};
        cN    = b[M];
        updZS = 1'b1;
      end
      OP_ROLC: begin
        resN = {b[M-1:0], cR};
        cN   = b[M];
      end
      OP_RORC: begin
        resN = {cR, b[M:1]};
        cN   = b[0];
      end
      OP_ROL: begin
        resN = {b[M-1:0], b[M]};
        cN   = b[M];
      end
      OP_ROR: begin
        resN = {b[0], b[M:1]};
        cN   = b[0];
      end
      OP_CLC:   cN = 1'b0;
      OP_SEC:   cN = 1'b1;
      OP_CLZ:   zN = 1'b0;
      OP_SEZ:   zN = 1'b1;
      OP_CLS:   sN = 1'b0;
      OP_SES:   sN = 1'b1;
      OP_PUSHF: resN = {{(BITS-4){1'b0}}, vR, sR, cR, zR};
      OP_POPF:  {vN, sN, cN, zN} = b[3:0];
      default:  ;
    endcase
    if (updZS) begin
      zN = (resN == '0);
      sN = resN[M];
    end
  end

  // ---------------- iterative multiplier ----------------
`ifdef SLURM_ALU_MUL_EN
  logic [BITS-1:0]   mcand, hiR, absA, absB, mulHi;
  logic [2*BITS-1:0] prodR, prodStep, prodFinal;
  logic [BITS:0]     partial;
  logic [SHW-1:0]    cnt;
  logic              negR, sgnR, isSigned;

  // muls runs on magnitudes; the sign is re-applied on the last step
  assign isSigned  = (op == OP_MULS);
  assign absA      = (isSigned && a[M]) ? -a : a;
  assign absB      = (isSigned && b[M]) ? -b : b;
  assign goMul     = accept && (op == OP_MUL || op == OP_MULS);
  assign mulDone   = (state == MUL) && (cnt == SHW'(BITS - 1));
  assign partial   = {1'b0, prodR[2*BITS-1:BITS]} + (prodR[0] ? {1'b0, mcand} : '0);
  assign prodStep  = {partial, prodR[BITS-1:1]};
  assign prodFinal = negR ? -prodStep : prodStep;
  assign mulLo     = prodFinal[M:0];
  assign mulHi     = prodFinal[2*BITS-1:BITS];
  assign mulZero   = (prodFinal == '0);
  assign mulSign   = prodFinal[2*BITS-1];
  assign mulOvf    = sgnR ? (mulHi != {BITS{mulLo[M]}}) : (mulHi != '0);
  assign hiVal     = hiR;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      mcand <= '0;
      prodR <= '0;
      cnt   <= '0;
      negR  <= 1'b0;
      sgnR  <= 1'b0;
      hiR   <= '0;
    end else if (goMul) begin
      mcand <= absA;
      prodR <= {{BITS{1'b0}}, absB};
      cnt   <= '0;
      negR  <= isSigned && (a[M] ^ b[M]);
      sgnR  <= isSigned;
    end else if (state == MUL) begin
      prodR <= prodStep;
      cnt   <= cnt + SHW'(1);
      if (mulDone) hiR <= mulHi;
    end
  end
`else
  assign goMul   = 1'b0;
  assign mulDone = 1'b0;
  assign mulLo   = '0;
  assign mulOvf  = 1'b0;
  assign mulZero = 1'b0;
  assign mulSign = 1'b0;
  assign hiVal   = '0;
`endif

  // ---------------- result / flag registers ----------------
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      outR  <= '0;
      cR    <= 1'b0;
      zR    <= 1'b0;
      sR    <= 1'b0;
      vR    <= 1'b0;
      doneR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      if (mulDone) begin
        outR  <= mulLo;
        cR    <= mulOvf;
        vR    <= mulOvf;
        zR    <= mulZero;
        sR    <= mulSign;
        doneR <= 1'b1;
      end else if (accept && !goMul) begin
        outR  <= resN;
        cR    <= cN;
        zR    <= zN;
        sR    <= sN;
        vR    <= vN;
        doneR <= 1'b1;
      end
    end
  end

  assign bus.busy   = busyC;
  assign bus.done   = doneR;
  assign bus.aluOut = outR;
  assign bus.C      = cR;
  assign bus.Z      = zR;
  assign bus.S      = sR;
  assign bus.V      = vR;
endmodule
